// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl -- trap controller for the single-cycle MIPS datapath.
//
// Produces the PC unit's trap selects (4 = interrupt vector 0x80000004,
// 5 = exception vector 0x80000008) together with the return address (EPC)
// that the datapath writes into $k0. External interrupt lines are
// synchronised, edge-detected and latched as pending bits; a mask and a
// fixed priority (lowest index wins) pick the serviced line. Once a trap is
// taken, further traps are blocked until the handler returns via eret.
//
// Optional build macro: TRAP_CAUSE_EN adds the cause and dbl_fault outputs.
//
// Ports:
//   CLK          in   system clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   irq_in       in   [NIRQ] async interrupt requests, rising-edge sensitive
//   mask_we      in   write irq mask this cycle
//   mask_wdata   in   [NIRQ] new mask, 1 = enabled
//   illop        in   current instruction is undefined
//   eret         in   current instruction is handler return
//   PC           in   [32] current PC
//   PCplus4      in   [32] PC+4 from PC unit
//   super_mode   in   supervisor mode flag (PC[31]); "super" is a reserved
//                     word in SystemVerilog, hence the longer name
//   trap_pcsrc   out  [3] 0 none, 4 interrupt, 5 exception
//   trap_valid   out  trap taken this cycle
//   epc_we       out  write epc_data to $k0 at this edge
//   epc_data     out  [32] return address
//   irq_pending  out  [NIRQ] latched pending bits
//   irq_mask     out  [NIRQ] current mask
//   in_handler   out  controller is in the HANDLER state
//   cause        out  [8] (TRAP_CAUSE_EN) 8'h80 exception, else irq index
//   dbl_fault    out  (TRAP_CAUSE_EN) sticky: illop seen in handler/kernel
// -----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int unsigned NIRQ = 4
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    input  logic            illop,
    input  logic            eret,
    input  logic [31:0]     PC,
    input  logic [31:0]     PCplus4,
    input  logic            super_mode,
    output logic [2:0]      trap_pcsrc,
    output logic            trap_valid,
    output logic            epc_we,
    output logic [31:0]     epc_data,
    output logic [NIRQ-1:0] irq_pending,
    output logic [NIRQ-1:0] irq_mask,
    output logic            in_handler
`ifdef TRAP_CAUSE_EN
    ,
    output logic [7:0]      cause,
    output logic            dbl_fault
`endif
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] sync1_q, sync1_d;
    logic [NIRQ-1:0] sync2_q, sync2_d;
    logic [NIRQ-1:0] sync3_q, sync3_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q, mask_d;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] active;
    logic [NIRQ-1:0] irq_sel;     // one-hot winner among active lines
    logic            irq_hit;
    logic [NIRQ-1:0] clr;
    logic            take_exc;
    logic            take_irq;

`ifdef TRAP_CAUSE_EN
    logic [2:0] irq_idx;
    logic [7:0] cause_q, cause_d;
    logic       dbl_fault_q, dbl_fault_d;
`endif

    // ---------------------------------------------------------------------
    // Synchroniser, edge detect, priority select
    // ---------------------------------------------------------------------
    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        rise    = sync2_q & ~sync3_q;
        active  = pending_q & mask_q;

        irq_sel = '0;
        irq_hit = 1'b0;
`ifdef TRAP_CAUSE_EN
        irq_idx = '0;
`endif
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (active[i] && !irq_hit) begin
                irq_hit    = 1'b1;
                irq_sel[i] = 1'b1;
`ifdef TRAP_CAUSE_EN
                irq_idx    = 3'(i);
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // Trap decision FSM: next state and combinational outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        trap_pcsrc = 3'd0;
        trap_valid = 1'b0;
        epc_we     = 1'b0;
        epc_data   = '0;
        clr        = '0;
        take_exc   = 1'b0;
        take_irq   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // Kernel code outside a handler never traps.
                if (!super_mode) begin
                    if (illop) begin
                        take_exc = 1'b1;
                    end else if (irq_hit) begin
                        take_irq = 1'b1;
                    end
                end

                if (take_exc) begin
                    trap_pcsrc = 3'd5;
                    epc_data   = PCplus4;
                end else if (take_irq) begin
                    // Aborted instruction re-executes on return.
                    trap_pcsrc = 3'd4;
                    epc_data   = PC;
                    clr        = irq_sel;
                end

                if (take_exc || take_irq) begin
                    trap_valid = 1'b1;
                    epc_we     = 1'b1;
                    state_d    = ST_HANDLER;
                end
            end

            ST_HANDLER: begin
                if (eret) begin
                    state_d = ST_RUN;
                end
            end

            default: state_d = ST_RUN;
        endcase

        // A fresh rise wins over a same-edge clear so no request is lost.
        pending_d = (pending_q & ~clr) | rise;
        // Trap decision above already used mask_q, so the write lands after.
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

`ifdef TRAP_CAUSE_EN
    always_comb begin
        cause_d     = cause_q;
        dbl_fault_d = dbl_fault_q;
        if (take_exc) begin
            cause_d = 8'h80;
        end else if (take_irq) begin
            cause_d = {5'b0, irq_idx};
        end
        if (illop && (state_q == ST_HANDLER || super_mode)) begin
            dbl_fault_d = 1'b1;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_RUN;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

`ifdef TRAP_CAUSE_EN
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cause_q     <= '0;
            dbl_fault_q <= 1'b0;
        end else begin
            cause_q     <= cause_d;
            dbl_fault_q <= dbl_fault_d;
        end
    end

    assign cause     = cause_q;
    assign dbl_fault = dbl_fault_q;
`endif

    assign irq_pending = pending_q;
    assign irq_mask    = mask_q;
    assign in_handler  = (state_q == ST_HANDLER);

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl -- directed self-checking bench for trap_ctrl (NIRQ = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam int unsigned NIRQ = 4;

    logic            CLK;
    logic            Reset_n;
    logic [NIRQ-1:0] irq_in;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wdata;
    logic            illop;
    logic            eret;
    logic [31:0]     PC;
    logic [31:0]     PCplus4;
    logic            super_mode;
    logic [2:0]      trap_pcsrc;
    logic            trap_valid;
    logic            epc_we;
    logic [31:0]     epc_data;
    logic [NIRQ-1:0] irq_pending;
    logic [NIRQ-1:0] irq_mask;
    logic            in_handler;
`ifdef TRAP_CAUSE_EN
    logic [7:0]      cause;
    logic            dbl_fault;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    trap_ctrl #(.NIRQ(NIRQ)) dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .illop       (illop),
        .eret        (eret),
        .PC          (PC),
        .PCplus4     (PCplus4),
        .super_mode  (super_mode),
        .trap_pcsrc  (trap_pcsrc),
        .trap_valid  (trap_valid),
        .epc_we      (epc_we),
        .epc_data    (epc_data),
        .irq_pending (irq_pending),
        .irq_mask    (irq_mask),
        .in_handler  (in_handler)
`ifdef TRAP_CAUSE_EN
        ,
        .cause       (cause),
        .dbl_fault   (dbl_fault)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        illop      = 1'b0;
        eret       = 1'b0;
        PC         = 32'h0000_0040;
        PCplus4    = 32'h0000_0044;
        super_mode = 1'b0;

        // ---- reset state ----
        #3;
        check("rst_pcsrc",   32'(trap_pcsrc), 32'd0);
        check("rst_valid",   32'(trap_valid), 32'd0);
        check("rst_epc_we",  32'(epc_we), 32'd0);
        check("rst_epc",     epc_data, 32'd0);
        check("rst_pending", 32'(irq_pending), 32'd0);
        check("rst_mask",    32'(irq_mask), 32'd0);
        check("rst_handler", 32'(in_handler), 32'd0);
`ifdef TRAP_CAUSE_EN
        check("rst_cause",   32'(cause), 32'd0);
        check("rst_dbl",     32'(dbl_fault), 32'd0);
`endif
        #9 Reset_n = 1'b1;   // t=12, between edges
        tick();

        // ---- irq2, mask 0100: 3-edge latency ----
        mask_we = 1'b1; mask_wdata = 4'b0100;
        tick();
        mask_we = 1'b0;
        check("mask_wr", 32'(irq_mask), 32'h4);
        irq_in = 4'b0100;
        tick(); tick();
        check("lat2_pcsrc",   32'(trap_pcsrc), 32'd0);
        check("lat2_pending", 32'(irq_pending), 32'h0);
        tick();
        check("irq2_pending", 32'(irq_pending), 32'h4);
        check("irq2_pcsrc",   32'(trap_pcsrc), 32'd4);
        check("irq2_valid",   32'(trap_valid), 32'd1);
        check("irq2_epc_we",  32'(epc_we), 32'd1);
        check("irq2_epc",     epc_data, 32'h0000_0040);
        tick();
        check("irq2_clr",     32'(irq_pending), 32'h0);
        check("irq2_hdl",     32'(in_handler), 32'd1);
        check("hdl_pcsrc",    32'(trap_pcsrc), 32'd0);
        check("hdl_epc_we",   32'(epc_we), 32'd0);
`ifdef TRAP_CAUSE_EN
        check("irq2_cause",   32'(cause), 32'h02);
`endif
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("eret_run", 32'(in_handler), 32'd0);

        // ---- exception beats a pending interrupt; super blocks traps ----
        super_mode = 1'b1;
        mask_we = 1'b1; mask_wdata = 4'b0010;
        irq_in = 4'b0010;
        tick();
        mask_we = 1'b0;
        tick(); tick();
        check("sup_pending", 32'(irq_pending), 32'h2);
        check("sup_pcsrc",   32'(trap_pcsrc), 32'd0);
        illop = 1'b1; PCplus4 = 32'h0000_0104;
        #1;
        check("sup_illop",   32'(trap_pcsrc), 32'd0);
        super_mode = 1'b0;
        #1;
        check("exc_pcsrc",   32'(trap_pcsrc), 32'd5);
        check("exc_epc",     epc_data, 32'h0000_0104);
        check("exc_valid",   32'(trap_valid), 32'd1);
        tick();
        illop = 1'b0;
        check("exc_keep",    32'(irq_pending), 32'h2);
        check("exc_hdl",     32'(in_handler), 32'd1);
`ifdef TRAP_CAUSE_EN
        check("exc_cause",   32'(cause), 32'h80);
`endif
        PC = 32'h0000_0200;
        eret = 1'b1;
        #1;
        check("eret_notrap", 32'(trap_pcsrc), 32'd0);
        tick();
        eret = 1'b0;
        check("irq1_pcsrc",  32'(trap_pcsrc), 32'd4);
        check("irq1_epc",    epc_data, 32'h0000_0200);
        tick();
        check("irq1_clr",    32'(irq_pending), 32'h0);
`ifdef TRAP_CAUSE_EN
        check("irq1_cause",  32'(cause), 32'h01);
`endif
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // ---- simultaneous rises on 0 and 3: lowest index first ----
        mask_we = 1'b1; mask_wdata = 4'hF;
        irq_in = 4'b1001;
        tick();
        mask_we = 1'b0;
        tick(); tick();
        check("dual_pending", 32'(irq_pending), 32'h9);
        check("dual_pcsrc",   32'(trap_pcsrc), 32'd4);
        tick();
        check("dual_first",   32'(irq_pending), 32'h8);
`ifdef TRAP_CAUSE_EN
        check("dual_cause0",  32'(cause), 32'h00);
`endif
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("dual_pcsrc2",  32'(trap_pcsrc), 32'd4);
        tick();
        check("dual_second",  32'(irq_pending), 32'h0);
`ifdef TRAP_CAUSE_EN
        check("dual_cause3",  32'(cause), 32'h03);
`endif

        // ---- irq pulse latched while in handler ----
        irq_in = 4'b1011;
        tick();
        irq_in = 4'b1001;
        tick(); tick();
        check("hdl_latch",   32'(irq_pending), 32'h2);
        check("hdl_block",   32'(trap_pcsrc), 32'd0);
        check("hdl_still",   32'(in_handler), 32'd1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("post_eret",   32'(trap_pcsrc), 32'd4);
        check("post_epc",    epc_data, 32'h0000_0200);
        tick();
        check("post_clr",    32'(irq_pending), 32'h0);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // ---- mask write in the trap cycle uses the old mask ----
        irq_in = 4'b0000;
        tick(); tick(); tick();
        irq_in = 4'b0001;
        tick(); tick(); tick();
        mask_we = 1'b1; mask_wdata = 4'h0;
        #1;
        check("mw_pcsrc",    32'(trap_pcsrc), 32'd4);
        tick();
        mask_we = 1'b0;
        check("mw_mask",     32'(irq_mask), 32'h0);
        check("mw_clr",      32'(irq_pending), 32'h0);
        check("mw_hdl",      32'(in_handler), 32'd1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        irq_in = 4'b1001;
        tick(); tick(); tick();
        check("mw_pend3",    32'(irq_pending), 32'h8);
        check("mw_blocked",  32'(trap_pcsrc), 32'd0);

        // ---- reset mid-handler ----
        illop = 1'b1; PCplus4 = 32'h0000_0300;
        #1;
        check("exc2_pcsrc",  32'(trap_pcsrc), 32'd5);
        check("exc2_epc",    epc_data, 32'h0000_0300);
        tick();
        check("exc2_hdl",    32'(in_handler), 32'd1);
        tick();                 // illop held inside the handler
        illop = 1'b0;
`ifdef TRAP_CAUSE_EN
        check("dbl_set",     32'(dbl_fault), 32'd1);
`endif
        check("pre_rst_pend", 32'(irq_pending), 32'h8);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_pending", 32'(irq_pending), 32'h0);
        check("arst_mask",    32'(irq_mask), 32'h0);
        check("arst_hdl",     32'(in_handler), 32'd0);
        check("arst_pcsrc",   32'(trap_pcsrc), 32'd0);
`ifdef TRAP_CAUSE_EN
        check("arst_dbl",     32'(dbl_fault), 32'd0);
        check("arst_cause",   32'(cause), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
